// File: rtl/seg7_defs.sv
// Shared constants for the binary-to-7-segment converter: digit patterns,
// FSM state encoding, display limit and the double-dabble nibble adjust.
package seg7_defs;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [13:0] MAX_DISPLAY = 14'd9999;
  localparam logic [3:0]  LAST_ITER   = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
  function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int unsigned i = 0; i < 4; i++) begin
      if (b[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD nibble to active-low 7-segment pattern.
// Non-decimal nibbles show a dash.
module seg7_decoder
  import seg7_defs::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    unique case (nibble_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/binary_to_segments.sv
// 14-bit binary to four 7-segment digits via a sequential double-dabble engine.
// Accept -> 14 shift cycles -> load; all four digits update together with done.
module binary_to_segments
  import seg7_defs::*;
#(
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] value,
  input  logic        value_valid,
  output logic        ready,
  output logic        done,
  output logic [6:0]  segment1,
  output logic [6:0]  segment2,
  output logic [6:0]  segment3,
  output logic [6:0]  segment4
);

  state_t           state_q, state_d;
  logic [13:0]      bin_q, bin_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             over_q, over_d;
  logic             done_q, done_d;
  logic [3:0][6:0]  seg_q, seg_d;

  logic [15:0]      bcd_adj;
  logic [3:0][6:0]  dec;
  logic [3:0]       blank;
  logic [3:0][6:0]  disp;

  assign bcd_adj = bcd_adjust(bcd_q);

  seg7_decoder u_dec0 (.nibble_i(bcd_q[3:0]),   .seg_o(dec[0]));
  seg7_decoder u_dec1 (.nibble_i(bcd_q[7:4]),   .seg_o(dec[1]));
  seg7_decoder u_dec2 (.nibble_i(bcd_q[11:8]),  .seg_o(dec[2]));
  seg7_decoder u_dec3 (.nibble_i(bcd_q[15:12]), .seg_o(dec[3]));

  // A digit blanks only when it and every digit above it are zero.
  always_comb begin
    blank    = '0;
    blank[3] = (BLANK_LEADING != 0) && (bcd_q[15:12] == 4'd0);
    blank[2] = blank[3] && (bcd_q[11:8] == 4'd0);
    blank[1] = blank[2] && (bcd_q[7:4] == 4'd0);
  end

  always_comb begin
    disp = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (over_q) begin
        disp[k] = SEG_DASH;
      end else if (blank[k]) begin
        disp[k] = SEG_BLANK;
      end else begin
        disp[k] = dec[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      over_q  <= 1'b0;
      done_q  <= 1'b0;
      seg_q   <= {4{SEG_BLANK}};
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      over_q  <= over_d;
      done_q  <= done_d;
      seg_q   <= seg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    over_d  = over_q;
    done_d  = 1'b0;
    seg_d   = seg_q;
    unique case (state_q)
      ST_IDLE: begin
        if (value_valid) begin
          bin_d   = value;
          bcd_d   = '0;
          cnt_d   = '0;
          over_d  = (value > MAX_DISPLAY);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj[14:0], bin_q, 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_ITER) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        seg_d   = disp;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ready    = (state_q == ST_IDLE);
  assign done     = done_q;
  assign segment1 = seg_q[0];
  assign segment2 = seg_q[1];
  assign segment3 = seg_q[2];
  assign segment4 = seg_q[3];

endmodule

// File: tb/tb_binary_to_segments.sv
// Directed and random checks of binary_to_segments against a decimal-arithmetic
// display model, with leading-zero blanking both enabled and disabled.
module tb_binary_to_segments;

  logic        clk;
  logic        rst_n;
  logic [13:0] value;
  logic        value_valid;
  logic        ready, done, ready_nb, done_nb;
  logic [6:0]  a1, a2, a3, a4, b1, b2, b3, b4;
  logic [3:0][6:0] segs_a, segs_b;

  int checks = 0;
  int errors = 0;

  assign segs_a = {a4, a3, a2, a1};
  assign segs_b = {b4, b3, b2, b1};

  binary_to_segments #(.BLANK_LEADING(1)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .value_valid(value_valid),
    .ready(ready), .done(done),
    .segment1(a1), .segment2(a2), .segment3(a3), .segment4(a4)
  );

  binary_to_segments #(.BLANK_LEADING(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .value(value), .value_valid(value_valid),
    .ready(ready_nb), .done(done_nb),
    .segment1(b1), .segment2(b2), .segment3(b3), .segment4(b4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] digit_pat(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  // Expected pattern of digit k (0 = units) for value v.
  function automatic logic [6:0] model(input int v, input int k, input bit blank_lead);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (v > 9999) return 7'b0111111;
    if (blank_lead && k > 0 && v < p) return 7'b1111111;
    return digit_pat((v / p) % 10);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_segs(input string tag, input int v);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s v=%0d blank seg%0d", tag, v, k + 1), 32'(segs_a[k]), 32'(model(v, k, 1'b1)));
      chk($sformatf("%s v=%0d noblank seg%0d", tag, v, k + 1), 32'(segs_b[k]), 32'(model(v, k, 1'b0)));
    end
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, " seg blank"}, 32'(segs_a), {4'h0, {4{7'b1111111}}});
    chk({tag, " seg_nb blank"}, 32'(segs_b), {4'h0, {4{7'b1111111}}});
  endtask

  task automatic wait_done(input string tag, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 30 && !got; i++) begin
      step();
      if (done) begin
        got = 1'b1;
        lat = i;
      end
    end
  endtask

  task automatic convert(input int v);
    int lat;
    value = 14'(v);
    value_valid = 1'b1;
    chk("ready before accept", 32'(ready), 32'd1);
    step();
    value_valid = 1'b0;
    chk("ready during shift", 32'(ready), 32'd0);
    wait_done("convert", lat);
    chk($sformatf("latency v=%0d", v), 32'(lat), 32'd15);
    chk("ready on done", 32'(ready), 32'd1);
    chk("done_nb aligned", 32'(done_nb), 32'd1);
    chk_segs("convert", v);
    step();
    chk("done single cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    int changes, dones, misaligned, nd;
    bit drop_next;
    logic [3:0][6:0] prev;

    rst_n = 1'b0;
    value = '0;
    value_valid = 1'b0;
    step(); step(); step();
    chk("reset ready", 32'(ready), 32'd1);
    chk("reset done", 32'(done), 32'd0);
    chk_blank("reset");
    rst_n = 1'b1;
    step();

    convert(1234);
    convert(7);
    convert(0);
    convert(1005);
    convert(10000);
    convert(16383);
    convert(9999);
    convert(10);
    convert(100);
    convert(1000);

    // Busy: 42 held during the shift is ignored, then accepted on the done cycle
    value = 14'd9999;
    value_valid = 1'b1;
    step();
    value = 14'd42;
    nd = 0;
    for (int i = 1; i <= 14; i++) begin
      step();
      if (ready !== 1'b0 || done !== 1'b0) nd++;
    end
    chk("busy ready/done low E1..E14", 32'(nd), 32'd0);
    step();
    chk("busy done", 32'(done), 32'd1);
    chk("busy ready on done", 32'(ready), 32'd1);
    chk_segs("busy first", 9999);
    step();
    value_valid = 1'b0;
    chk("42 accepted on done cycle", 32'(ready), 32'd0);
    chk("done dropped", 32'(done), 32'd0);
    chk_segs("busy hold", 9999);
    wait_done("busy second", lat);
    chk("busy second latency", 32'(lat), 32'd15);
    chk_segs("busy second", 42);
    step();

    // Reset at E7 aborts the conversion
    value = 14'd5555;
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
    for (int i = 1; i <= 6; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort ready", 32'(ready), 32'd1);
    chk("abort done", 32'(done), 32'd0);
    chk_blank("abort");
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) nd++;
    end
    chk("abort no done", 32'(nd), 32'd0);
    chk_blank("abort later");

    // Reset wins over a simultaneous handshake
    rst_n = 1'b0;
    value = 14'd3;
    value_valid = 1'b1;
    step();
    rst_n = 1'b1;
    value_valid = 1'b0;
    chk("reset-vs-handshake ready", 32'(ready), 32'd1);
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) nd++;
    end
    chk("reset-vs-handshake no done", 32'(nd), 32'd0);

    // Back-to-back 8888 then 0001 with valid held
    value = 14'd8888;
    value_valid = 1'b1;
    prev = segs_a;
    changes = 0;
    dones = 0;
    misaligned = 0;
    drop_next = 1'b0;
    for (int i = 0; i < 60 && dones < 2; i++) begin
      step();
      if (drop_next) begin
        value_valid = 1'b0;
        drop_next = 1'b0;
      end
      if (segs_a !== prev) begin
        changes++;
        if (!done) misaligned++;
        prev = segs_a;
      end
      if (done) begin
        dones++;
        if (dones == 1) begin
          chk_segs("b2b first", 8888);
          value = 14'd1;
          drop_next = 1'b1;
        end
      end
    end
    value_valid = 1'b0;
    chk("b2b changes", 32'(changes), 32'd2);
    chk("b2b dones", 32'(dones), 32'd2);
    chk("b2b misaligned", 32'(misaligned), 32'd0);
    chk_segs("b2b second", 1);
    step();

    for (int i = 0; i < 24; i++) begin
      if (i % 4 == 3) convert(int'($urandom_range(10000, 16383)));
      else convert(int'($urandom_range(0, 9999)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
